// File: rtl/writeback_dma_if.sv
// Bus bundle between the writeback DMA, its result buffer read port and the AXI write channels.
// The master modport is the DMA side; the slave modport is the buffer/interconnect side.
interface writeback_dma_if #(
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DATA_WIDTH_ACCUM     = 32,
    parameter int ADDR_WIDTH           = 10
);
    logic [ADDR_WIDTH-1:0]                            buf_rd_addr;
    logic                                             buf_rd_en;
    logic [DATA_WIDTH_ACCUM*SYSTOLIC_ARRAY_WIDTH-1:0] buf_rd_data;

    logic [31:0]                     awaddr;
    logic [7:0]                      awlen;
    logic [2:0]                      awsize;
    logic [1:0]                      awburst;
    logic                            awvalid;
    logic                            awready;

    logic [DATA_WIDTH_ACCUM-1:0]     wdata;
    logic [DATA_WIDTH_ACCUM/8-1:0]   wstrb;
    logic                            wlast;
    logic                            wvalid;
    logic                            wready;

    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;

    modport master (
        output buf_rd_addr, buf_rd_en,
        input  buf_rd_data,
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  buf_rd_addr, buf_rd_en,
        output buf_rd_data,
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/writeback_dma.sv
// Copies rows of the accumulator result buffer to external memory, one AXI INCR burst per row.
// state   | meaning
// IDLE    | waiting for start_pulse
// RD      | buffer read strobe for the current row
// RD_WAIT | buffer data arrives, captured into the row register
// AW      | write address offered until accepted
// W       | row words streamed, one per accepted beat
// B       | waiting for the write response, then next row or finish
// DONE    | completion; done_irq pulses on the following cycle
module writeback_dma #(
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DATA_WIDTH_ACCUM     = 32,
    parameter int ADDR_WIDTH           = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_pulse,
    input  logic [31:0]           dest_addr,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [15:0]           length,
    output logic                  done_irq,
    output logic                  busy,
    output logic                  err,
    writeback_dma_if.master       bus
);
    localparam int              BYTES_PER_WORD = DATA_WIDTH_ACCUM / 8;
    localparam int              BEAT_W    = (SYSTOLIC_ARRAY_WIDTH > 1) ? $clog2(SYSTOLIC_ARRAY_WIDTH) : 1;
    localparam logic [31:0]     ROW_BYTES = 32'(SYSTOLIC_ARRAY_WIDTH * BYTES_PER_WORD);
    localparam logic [7:0]      AW_LEN    = 8'(SYSTOLIC_ARRAY_WIDTH - 1);
    localparam logic [2:0]      AW_SIZE   = 3'($clog2(BYTES_PER_WORD));
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(SYSTOLIC_ARRAY_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, RD, RD_WAIT, AW, W, B, DONE
    } state_t;

    state_t                                         state, state_nxt;
    logic [31:0]                                    dest_q;
    logic [ADDR_WIDTH-1:0]                          src_q;
    logic [15:0]                                    len_q;
    logic [15:0]                                    row_cnt;
    logic [15:0]                                    row_cnt_inc;
    logic [BEAT_W-1:0]                              beat;
    logic [DATA_WIDTH_ACCUM*SYSTOLIC_ARRAY_WIDTH-1:0] row_q;
    logic [DATA_WIDTH_ACCUM-1:0]                    row_words [SYSTOLIC_ARRAY_WIDTH];

    for (genvar g = 0; g < SYSTOLIC_ARRAY_WIDTH; g++) begin : g_row
        assign row_words[g] = row_q[g*DATA_WIDTH_ACCUM +: DATA_WIDTH_ACCUM];
    end

    assign row_cnt_inc = row_cnt + 16'd1;

    // Bus outputs are decoded from state so reset forces them to zero immediately.
    always_comb begin
        state_nxt       = state;
        busy            = (state != IDLE);
        bus.buf_rd_en   = 1'b0;
        bus.buf_rd_addr = '0;
        bus.awvalid     = 1'b0;
        bus.awaddr      = '0;
        bus.awlen       = '0;
        bus.awsize      = '0;
        bus.awburst     = '0;
        bus.wvalid      = 1'b0;
        bus.wdata       = '0;
        bus.wstrb       = '0;
        bus.wlast       = 1'b0;
        bus.bready      = 1'b0;
        case (state)
            IDLE: begin
                if (start_pulse) state_nxt = (length == 16'd0) ? DONE : RD;
            end
            RD: begin
                bus.buf_rd_en   = 1'b1;
                bus.buf_rd_addr = src_q + ADDR_WIDTH'(row_cnt);
                state_nxt       = RD_WAIT;
            end
            RD_WAIT: state_nxt = AW;
            AW: begin
                bus.awvalid = 1'b1;
                bus.awaddr  = dest_q + {16'd0, row_cnt} * ROW_BYTES;
                bus.awlen   = AW_LEN;
                bus.awsize  = AW_SIZE;
                bus.awburst = 2'b01;
                if (bus.awready) state_nxt = W;
            end
            W: begin
                bus.wvalid = 1'b1;
                bus.wdata  = row_words[beat];
                bus.wstrb  = '1;
                bus.wlast  = (beat == LAST_BEAT);
                if (bus.wready && bus.wlast) state_nxt = B;
            end
            B: begin
                bus.bready = 1'b1;
                if (bus.bvalid) state_nxt = (row_cnt_inc == len_q) ? DONE : RD;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dest_q   <= '0;
            src_q    <= '0;
            len_q    <= '0;
            row_cnt  <= '0;
            beat     <= '0;
            row_q    <= '0;
            err      <= 1'b0;
            done_irq <= 1'b0;
        end else begin
            state    <= state_nxt;
            done_irq <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start_pulse) begin
                        dest_q  <= dest_addr;
                        src_q   <= src_addr;
                        len_q   <= length;
                        row_cnt <= '0;
                        err     <= 1'b0;
                    end
                end
                RD_WAIT: row_q <= bus.buf_rd_data;
                AW:      beat  <= '0;
                W: begin
                    if (bus.wready) beat <= beat + 1'b1;
                end
                B: begin
                    if (bus.bvalid) begin
                        if (bus.bresp != 2'b00) err <= 1'b1;
                        row_cnt <= row_cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_writeback_dma.sv
// Randomized bench for writeback_dma: buffer memory, AXI slave with configurable stalls,
// and a row-level reference of which reads, bursts and data each command must produce.
module tb_writeback_dma;
    localparam int SW       = 16;
    localparam int DW       = 32;
    localparam int ADDR_W   = 10;
    localparam int ROW_BITS = SW * DW;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_pulse;
    logic [31:0]       dest_addr;
    logic [ADDR_W-1:0] src_addr;
    logic [15:0]       length;
    logic              done_irq, busy, err;

    writeback_dma_if #(.SYSTOLIC_ARRAY_WIDTH(SW), .DATA_WIDTH_ACCUM(DW), .ADDR_WIDTH(ADDR_W)) bus ();

    writeback_dma #(.SYSTOLIC_ARRAY_WIDTH(SW), .DATA_WIDTH_ACCUM(DW), .ADDR_WIDTH(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_pulse(start_pulse),
        .dest_addr  (dest_addr),
        .src_addr   (src_addr),
        .length     (length),
        .done_irq   (done_irq),
        .busy       (busy),
        .err        (err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [ROW_BITS-1:0] mem [DEPTH];

    // slave behaviour knobs
    int aw_delay, w_mode, b_delay, err_row;
    int aw_wait, b_wait;
    bit b_pending, rd_pend;
    logic [ADDR_W-1:0] rd_pend_addr;

    // reference state for the active command
    bit          model_busy, exp_err, exp_err_nxt, in_flight, done_seen;
    int          exp_src, exp_len;
    logic [31:0] exp_dest;
    int          rows_rd, rows_aw, rows_b, beat, done_cnt;
    bit          aw_stall, w_stall;
    logic [31:0] prev_awaddr;
    logic [DW-1:0] prev_wdata;
    logic        prev_wlast;
    int          rd_log [$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [ROW_BITS-1:0] rand_row();
        logic [ROW_BITS-1:0] r;
        for (int i = 0; i < SW; i++) r[i*DW +: DW] = $urandom();
        return r;
    endfunction

    function automatic logic [DW-1:0] row_word(input logic [ROW_BITS-1:0] r, input int i);
        return r[i*DW +: DW];
    endfunction

    task automatic reset_model();
        model_busy = 0; exp_err = 0; exp_err_nxt = 0; in_flight = 0;
        b_pending = 0; rd_pend = 0; aw_wait = 0; aw_stall = 0; w_stall = 0;
        beat = 0; done_seen = 0; done_cnt = 0;
    endtask

    task automatic monitor();
        logic [31:0] exp_aw;
        if (done_irq) begin
            check_val("done_while_busy", model_busy, 1);
            check_val("done_rows", rows_b, exp_len);
            model_busy = 0;
            done_seen  = 1;
            done_cnt++;
        end
        exp_err = exp_err_nxt;
        check_val("err", err, exp_err);
        check_val("busy", busy, model_busy);

        if (bus.buf_rd_en) begin
            check_val("rd_addr", bus.buf_rd_addr, (exp_src + rows_rd) % DEPTH);
            check_val("rd_phase", in_flight, 0);
            rd_log.push_back(int'(bus.buf_rd_addr));
            rows_rd++;
            rd_pend      = 1;
            rd_pend_addr = bus.buf_rd_addr;
        end else begin
            rd_pend = 0;
        end

        if (aw_stall) begin
            check_val("aw_hold_valid", bus.awvalid, 1);
            check_val("aw_hold_addr", bus.awaddr, prev_awaddr);
        end
        if (bus.awvalid) begin
            check_val("aw_single", in_flight, 0);
            if (bus.awready) begin
                exp_aw = exp_dest + 32'(rows_aw * SW * (DW / 8));
                check_val("awaddr", bus.awaddr, exp_aw);
                check_val("awlen", bus.awlen, SW - 1);
                check_val("awsize", bus.awsize, $clog2(DW / 8));
                check_val("awburst", bus.awburst, 1);
                rows_aw++;
                in_flight = 1;
                beat      = 0;
                aw_wait   = 0;
                aw_stall  = 0;
            end else begin
                aw_wait++;
                aw_stall    = 1;
                prev_awaddr = bus.awaddr;
            end
        end else begin
            aw_stall = 0;
        end

        if (w_stall) begin
            check_val("w_hold_valid", bus.wvalid, 1);
            check_val("w_hold_data", bus.wdata, prev_wdata);
            check_val("w_hold_last", bus.wlast, prev_wlast);
        end
        if (bus.wvalid) begin
            check_val("w_phase", in_flight && beat < SW, 1);
            if (bus.wready) begin
                check_val("wdata", bus.wdata, row_word(mem[(exp_src + rows_aw - 1) % DEPTH], beat));
                check_val("wlast", bus.wlast, beat == SW - 1);
                check_val("wstrb", bus.wstrb, {(DW/8){1'b1}});
                beat++;
                w_stall = 0;
                if (beat == SW) begin
                    b_pending = 1;
                    b_wait    = b_delay;
                end
            end else begin
                w_stall    = 1;
                prev_wdata = bus.wdata;
                prev_wlast = bus.wlast;
            end
        end else begin
            w_stall = 0;
        end

        if (bus.bready) begin
            check_val("b_phase", in_flight && beat == SW, 1);
            if (bus.bvalid) begin
                if (bus.bresp != 2'b00) exp_err_nxt = 1;
                rows_b++;
                in_flight = 0;
                b_pending = 0;
            end
        end

        if (start_pulse && !model_busy) begin
            model_busy  = 1;
            exp_src     = int'(src_addr);
            exp_dest    = dest_addr;
            exp_len     = int'(length);
            exp_err_nxt = 0;
            rows_rd = 0; rows_aw = 0; rows_b = 0;
            rd_log.delete();
        end
    endtask

    // Drive slave inputs just after the rising edge, observe at the falling edge.
    task automatic cycle();
        bus.awready = (aw_wait >= aw_delay);
        if (w_mode == 0)      bus.wready = 1'b1;
        else if (w_mode == 1) bus.wready = ~bus.wready;
        else                  bus.wready = 1'($urandom_range(0, 1));
        if (b_pending && b_wait == 0) begin
            bus.bvalid = 1'b1;
            bus.bresp  = (rows_b == err_row) ? 2'b10 : 2'b00;
        end else begin
            bus.bvalid = 1'b0;
            bus.bresp  = 2'b00;
            if (b_pending) b_wait--;
        end
        bus.buf_rd_data = rd_pend ? mem[rd_pend_addr] : rand_row();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input int src, input logic [31:0] dest, input int len,
                           input int second_start_at, input int abort_row, output int lat);
        done_seen   = 0;
        done_cnt    = 0;
        start_pulse = 1'b1;
        src_addr    = ADDR_W'(src);
        dest_addr   = dest;
        length      = 16'(len);
        cycle();
        lat = 0;
        while (!done_seen && lat < 4000) begin
            if (lat == second_start_at) begin
                start_pulse = 1'b1;
                src_addr    = ADDR_W'($urandom);
                dest_addr   = $urandom;
                length      = 16'($urandom_range(1, 5));
            end else begin
                start_pulse = 1'b0;
                src_addr    = ADDR_W'($urandom);
                dest_addr   = $urandom;
                length      = 16'($urandom);
            end
            if (abort_row >= 0 && rows_b == abort_row && rows_aw == abort_row + 1 && beat >= 2)
                return;
            cycle();
            lat++;
        end
        start_pulse = 1'b0;
        check_val("done_seen", done_seen, 1);
        repeat (3) cycle();
        check_val("done_count", done_cnt, 1);
        check_val("rows_read", rows_rd, len);
        check_val("rows_burst", rows_aw, len);
        check_val("rows_resp", rows_b, len);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done_irq, 0);
        check_val({tag, "_err"}, err, 0);
        check_val({tag, "_rd_en"}, bus.buf_rd_en, 0);
        check_val({tag, "_rd_addr"}, bus.buf_rd_addr, 0);
        check_val({tag, "_awvalid"}, bus.awvalid, 0);
        check_val({tag, "_awaddr"}, bus.awaddr, 0);
        check_val({tag, "_wvalid"}, bus.wvalid, 0);
        check_val({tag, "_wdata"}, bus.wdata, 0);
        check_val({tag, "_wlast"}, bus.wlast, 0);
        check_val({tag, "_bready"}, bus.bready, 0);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < DEPTH; i++) mem[i] = rand_row();
        rst = 1'b1;
        start_pulse = 1'b0; dest_addr = '0; src_addr = '0; length = '0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
        bus.buf_rd_data = '0;
        aw_delay = 0; w_mode = 0; b_delay = 0; err_row = -1;
        reset_model();
        #1;
        check_outputs_zero("reset");
        @(posedge clk); #1;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();

        // two rows, everything ready
        run_cmd(5, 32'h0000_1000, 2, -1, -1, lat);

        // zero length: completion two cycles after the start cycle
        run_cmd($urandom_range(0, DEPTH - 1), $urandom, 0, -1, -1, lat);
        check_val("len0_latency", lat, 2);

        // wready toggling, awready held off for three cycles
        aw_delay = 3; w_mode = 1;
        run_cmd($urandom_range(0, DEPTH - 1), $urandom, 2, -1, -1, lat);
        aw_delay = 0; w_mode = 0;

        // slave error on row 0 of 3; err must survive until the next start
        err_row = 0; b_delay = 1;
        run_cmd($urandom_range(0, DEPTH - 1), 32'h2000_0000, 3, -1, -1, lat);
        repeat (4) cycle();
        check_val("err_sticky", err, 1);
        err_row = -1; b_delay = 0;
        run_cmd($urandom_range(0, DEPTH - 1), 32'h3000_0000, 1, -1, -1, lat);
        check_val("err_cleared", err, 0);

        // buffer address wrap plus an ignored start mid-transfer
        run_cmd(1022, 32'h0000_8000, 3, 5, -1, lat);
        check_val("wrap_reads", rd_log.size(), 3);
        if (rd_log.size() == 3) begin
            check_val("wrap_rd0", rd_log[0], 1022);
            check_val("wrap_rd1", rd_log[1], 1023);
            check_val("wrap_rd2", rd_log[2], 0);
        end

        // reset in the middle of row 1's data phase
        run_cmd($urandom_range(0, DEPTH - 1), 32'h4000_0000, 3, -1, 1, lat);
        #2 rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        reset_model();
        repeat (3) cycle();
        check_val("midrst_no_done", done_cnt, 0);
        rst = 1'b0;
        cycle();
        run_cmd($urandom_range(0, DEPTH - 1), 32'h5000_0000, 2, -1, -1, lat);

        // randomized commands with random back-pressure and error placement
        for (int k = 0; k < 8; k++) begin
            aw_delay = $urandom_range(0, 3);
            w_mode   = 2;
            b_delay  = $urandom_range(0, 3);
            err_row  = $urandom_range(0, 4);
            run_cmd($urandom_range(0, DEPTH - 1), $urandom, $urandom_range(0, 3), -1, -1, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_dma.md
WRITEBACK_DMA -- requirements
Module: writeback_dma

Interface
REQ-001 Parameter SYSTOLIC_ARRAY_WIDTH, default 16, beats per row (one accumulator word per column).
REQ-002 Parameter DATA_WIDTH_ACCUM, default 32, width of each buffer word and of the AXI write data bus.
REQ-003 Parameter ADDR_WIDTH, default 10, result-buffer row address width.
REQ-004 clk  in  1  single clock; all logic is sampled on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start_pulse  in  1  one-cycle command strobe from the control unit.
REQ-007 dest_addr  in  32  external byte base address, sampled with start_pulse.
REQ-008 src_addr  in  ADDR_WIDTH  first buffer row, sampled with start_pulse.
REQ-009 length  in  16  number of rows to transfer, sampled with start_pulse.
REQ-010 done_irq  out  1  one-cycle completion pulse.
REQ-011 busy  out  1  high from the accepted start until the cycle done_irq pulses.
REQ-012 err  out  1  sticky flag for a non-OKAY write response; cleared by the next accepted start.
REQ-013 buf_rd_addr  out  ADDR_WIDTH  result-buffer read row.
REQ-014 buf_rd_en  out  1  result-buffer read strobe.
REQ-015 buf_rd_data  in  DATA_WIDTH_ACCUM x SYSTOLIC_ARRAY_WIDTH  row data, valid exactly 1 cycle after buf_rd_en.
REQ-016 awaddr/awlen/awsize/awburst/awvalid  out  32/8/3/2/1; awready  in  1.
REQ-017 wdata/wstrb/wlast/wvalid  out  DATA_WIDTH_ACCUM/DATA_WIDTH_ACCUM/8/1/1; wready  in  1.
REQ-018 bresp  in  2; bvalid  in  1; bready  out  1.

Function
REQ-019 FSM states: IDLE, RD, RD_WAIT, AW, W, B, DONE.
REQ-020 IDLE: start_pulse latches dest_addr, src_addr and length, clears err and row_cnt, and transitions to RD, or to DONE if length==0.
REQ-021 start_pulse in any state other than IDLE is ignored; busy stays high and latched parameters are unchanged.
REQ-022 RD: buf_rd_en=1 for exactly one cycle with buf_rd_addr = src + row_cnt (mod 2^ADDR_WIDTH, wrapping silently); then RD_WAIT.
REQ-023 RD_WAIT: capture buf_rd_data into the row register; then AW.
REQ-024 AW: awvalid=1 with awaddr = dest + row_cnt*SYSTOLIC_ARRAY_WIDTH*(DATA_WIDTH_ACCUM/8) (32-bit wrap), awlen = SYSTOLIC_ARRAY_WIDTH-1, awsize = log2(DATA_WIDTH_ACCUM/8), awburst = INCR (2'b01).
REQ-025 AW: awvalid and all AW fields hold stable until awready; on the handshake, go to W.
REQ-026 W: wvalid=1, wdata = row word[beat], wstrb all ones, beat advancing only on wvalid&&wready, wlast=1 only on beat SYSTOLIC_ARRAY_WIDTH-1; after the last handshake, go to B.
REQ-027 W: wdata/wlast hold stable while wvalid && !wready.
REQ-028 B: bready=1; on bvalid, if bresp != 2'b00 set err, then increment row_cnt.
REQ-029 After B: if row_cnt == length go to DONE, else go to RD.
REQ-030 Do not abort on error; all rows are still written.
REQ-031 DONE: done_irq=1 for one cycle, busy=0 in the same cycle; next state IDLE.
REQ-032 awvalid, wvalid and bready are never asserted outside their own states; the block never has more than one outstanding burst.
REQ-033 The row register is not overwritten while in AW, W or B.

Reset
REQ-034 On rst asserted, immediately: state=IDLE; busy, done_irq, buf_rd_en, awvalid, wvalid, wlast, bready, err all 0; row_cnt and beat 0; buf_rd_addr, awaddr, wdata 0.
REQ-035 A reset mid-transfer abandons the burst with no completion pulse; the first post-reset start begins a fresh command.

Verification
REQ-036 src=5, dest=0x1000, length=2, ready signals tied high -> bursts at 0x1000 and 0x1040, awlen=15, 16 beats each, wlast on beat 15, single done_irq, err=0.
REQ-037 length=0 -> no buf_rd_en and no awvalid; done_irq exactly 2 cycles after start_pulse.
REQ-038 wready toggling 1/0 every cycle and awready delayed 3 cycles -> data order and wlast correct, AW/W fields stable while stalled.
REQ-039 bresp=2'b10 on row 0 of 3 -> err=1 after that response, all 3 bursts still issued, done_irq pulses, err stays 1 until the next start.
REQ-040 src=1022, length=3, ADDR_WIDTH=10 -> buf_rd_addr sequence 1022, 1023, 0; a second start_pulse during the transfer is ignored.
REQ-041 rst asserted during W of row 1 -> all outputs 0 immediately, no done_irq; a new start then completes normally.
